mult_datapath: RTL

Shift-add datapath for the 8×8 signed multiplier. It sits directly downstream of the control unit `CU`:
- consumes `load`, `enable`, `Psel`, `done`;
- returns `z_flag` and `b0`.

On `done` it captures the signed product and runs a sequential binary-to-BCD conversion. The display stage uses the BCD digits, selected by the `CU` scroll controls.

---
 rtl/mult_datapath.sv | 116 +++++++++++
 1 files changed

// File: rtl/mult_datapath.sv
// Shift-add datapath for the 8x8 signed multiplier with a sequential
// double-dabble binary-to-BCD converter for the display stage.
module mult_datapath #(
  parameter int N      = 8,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N-1:0]          a,
  input  logic [N-1:0]          b,
  input  logic                  load,
  input  logic                  enable,
  input  logic                  Psel,
  input  logic                  done,
  output logic                  z_flag,
  output logic                  b0,
  output logic [2*N-1:0]        product,
  output logic                  sign,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  bcd_valid
);

  localparam int W  = 2 * N;
  localparam int CW = $clog2(W + 1);
  localparam int BW = 4 * DIGITS;

  typedef enum logic {IDLE, CONV} state_t;

  state_t          state;
  logic [W-1:0]    mcand;
  logic [W-1:0]    acc;
  logic [W-1:0]    bin;
  logic [N-1:0]    mplier;
  logic [N-1:0]    a_mag;
  logic [N-1:0]    b_mag;
  logic            sgn;
  logic [BW-1:0]   bcd_reg;
  logic [BW-1:0]   bcd_adj;
  logic [CW-1:0]   cnt;

  // |-2^(N-1)| wraps to 2^(N-1), which is correct when read as unsigned.
  assign a_mag  = a[N-1] ? -a : a;
  assign b_mag  = b[N-1] ? -b : b;
  assign z_flag = (mplier == '0);
  assign b0     = mplier[0];
  assign bcd    = bcd_reg;

  // NOTE: always_comb assigns a full default first so no latch is inferred.
  always_comb begin
    bcd_adj = bcd_reg;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_reg[4*i +: 4] >= 4'd5)
        bcd_adj[4*i +: 4] = bcd_reg[4*i +: 4] + 4'd3;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      sgn    <= 1'b0;
    end else if (load) begin
      mcand  <= {{N{1'b0}}, a_mag};
      mplier <= b_mag;
      acc    <= '0;
      sgn    <= a[N-1] ^ b[N-1];
    end else if (enable) begin
      if (Psel)
        acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      product   <= '0;
      sign      <= 1'b0;
      bin       <= '0;
      bcd_reg   <= '0;
      cnt       <= '0;
      bcd_valid <= 1'b0;
    end else if (load) begin
      // New operands abandon any conversion in flight.
      state     <= IDLE;
      bcd_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (done) begin
            product <= sgn ? -acc : acc;
            sign    <= sgn & (acc != '0);
            bin     <= acc;
            bcd_reg <= '0;
            cnt     <= CW'(W);
            state   <= CONV;
          end
        end
        CONV: begin
          {bcd_reg, bin} <= {bcd_adj, bin} << 1;
          cnt            <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state     <= IDLE;
            bcd_valid <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
